// File: rtl/serial_cmd_pkg.sv
// Shared command/response byte codes and parser state encoding
// for the host serial command engine.
package serial_cmd_pkg;

    localparam logic [7:0] CMD_RESET = 8'h52;
    localparam logic [7:0] CMD_SETUP = 8'h53;
    localparam logic [7:0] CMD_FRAME = 8'h41;
    localparam logic [7:0] CMD_PING  = 8'hAA;
    localparam logic [7:0] CMD_POWER = 8'h50;
    localparam logic [7:0] CMD_BULK  = 8'h51;

    localparam logic [7:0] RSP_ACK     = 8'h01;
    localparam logic [7:0] RSP_PONG    = 8'h55;
    localparam logic [7:0] RSP_OVERRUN = 8'hB0;
    localparam logic [7:0] RSP_BADRUN  = 8'hFE;
    localparam logic [7:0] RSP_UNKNOWN = 8'hFF;
    localparam logic [7:0] RSP_TIMEOUT = 8'hFC;
    localparam logic [7:0] RSP_REQUEST = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKIP,
        ST_SETUP,
        ST_FRAME,
        ST_ERR_HOLD
    } parse_state_e;

endpackage

// File: rtl/serial_cmd_engine_resp_fifo.sv
// Byte-wide first-word fall-through response queue.
// A push into a full queue is accepted only when a pop happens alongside it.
module resp_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_byte,
    input  logic                       pop,
    output logic [7:0]                 head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/serial_cmd_engine.sv
// Host command parser: decodes the UART byte stream, assembles console
// frames, queues responses and issues flow-control frame requests.
module serial_cmd_engine
    import serial_cmd_pkg::*;
#(
    parameter int NUM_CONSOLES   = 1,
    parameter int FRAME_BYTES    = 4,
    parameter int RESP_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic                     tx_valid,
    output logic [7:0]               tx_byte,
    input  logic                     tx_ready,
    input  logic [NUM_CONSOLES-1:0]  request_frame,
    output logic                     frame_wr_en,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     controller_reset,
    output logic [31:0]              frame_count,
    output logic                     prebuffer_done,
    output logic                     resp_overflow
);

    localparam int FW = 8 * FRAME_BYTES;
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    parse_state_e  state;
    logic [4:0]    idx;
    logic [FW-1:0] shift_q;
    logic [TW-1:0] tmo_cnt;
    logic          pend_valid;
    logic [7:0]    pend_byte;
    logic          lock;

    logic          all_ready;
    logic          tx_pop;
    logic [CW-1:0] fifo_count;
    logic          drop;

    logic          cmd_push;
    logic [7:0]    cmd_byte;
    logic          cmd_second;
    logic [7:0]    cmd_second_byte;
    logic          timeout;
    logic          frame_done;
    logic [FW-1:0] frame_next;
    logic          req_push;
    logic          push;
    logic [7:0]    push_byte;

    assign all_ready = &request_frame;
    assign tx_pop    = tx_valid && tx_ready;
    assign drop      = push && (fifo_count == CW'(RESP_DEPTH)) && !tx_pop;

    always_comb begin
        cmd_push        = 1'b0;
        cmd_byte        = 8'h00;
        cmd_second      = 1'b0;
        cmd_second_byte = 8'h00;
        timeout         = (state == ST_SKIP || state == ST_SETUP ||
                           state == ST_FRAME) && !rx_valid &&
                          (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        frame_next      = (shift_q << 8) | FW'(rx_byte);
        frame_done      = rx_valid && (state == ST_FRAME) &&
                          (idx == 5'(FRAME_BYTES));
        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    case (rx_byte)
                        CMD_RESET: begin
                            cmd_push        = 1'b1;
                            cmd_byte        = RSP_ACK;
                            cmd_second      = 1'b1;
                            cmd_second_byte = CMD_RESET;
                        end
                        CMD_SETUP, CMD_FRAME, CMD_POWER, CMD_BULK: ;
                        CMD_PING: begin
                            cmd_push = 1'b1;
                            cmd_byte = RSP_PONG;
                        end
                        default: begin
                            cmd_push = 1'b1;
                            cmd_byte = RSP_UNKNOWN;
                        end
                    endcase
                end
                ST_SETUP: begin
                    if (idx == 5'd1 && rx_byte != CMD_FRAME) begin
                        cmd_push = 1'b1;
                        cmd_byte = RSP_BADRUN;
                    end else if (idx == 5'd4) begin
                        cmd_push        = 1'b1;
                        cmd_byte        = RSP_ACK;
                        cmd_second      = 1'b1;
                        cmd_second_byte = CMD_SETUP;
                    end
                end
                ST_FRAME: begin
                    if (frame_done && !all_ready) begin
                        cmd_push = 1'b1;
                        cmd_byte = RSP_OVERRUN;
                    end
                end
                default: ;
            endcase
        end else if (timeout) begin
            cmd_push = 1'b1;
            cmd_byte = RSP_TIMEOUT;
        end

        // Queued second byte wins, then command responses, then requests.
        req_push  = prebuffer_done && all_ready && !lock &&
                    !pend_valid && !cmd_push;
        push      = 1'b0;
        push_byte = 8'h00;
        if (pend_valid) begin
            push      = 1'b1;
            push_byte = pend_byte;
        end else if (cmd_push) begin
            push      = 1'b1;
            push_byte = cmd_byte;
        end else if (req_push) begin
            push      = 1'b1;
            push_byte = RSP_REQUEST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            idx              <= '0;
            shift_q          <= '0;
            tmo_cnt          <= '0;
            pend_valid       <= 1'b0;
            pend_byte        <= 8'h00;
            lock             <= 1'b0;
            frame_wr_en      <= 1'b0;
            frame_data       <= '0;
            controller_reset <= 1'b0;
            frame_count      <= '0;
            prebuffer_done   <= 1'b0;
            resp_overflow    <= 1'b0;
        end else begin
            controller_reset <= 1'b0;
            frame_wr_en      <= 1'b0;
            pend_valid       <= cmd_second;
            if (cmd_second) begin
                pend_byte <= cmd_second_byte;
            end
            if (request_frame == '0) begin
                prebuffer_done <= 1'b1;
            end
            if (drop) begin
                resp_overflow <= 1'b1;
            end
            if (req_push) begin
                lock <= 1'b1;
            end
            if (rx_valid || state == ST_IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        case (rx_byte)
                            CMD_RESET: begin
                                controller_reset <= 1'b1;
                                frame_count      <= '0;
                                prebuffer_done   <= 1'b0;
                                lock             <= 1'b0;
                            end
                            CMD_SETUP: begin
                                state <= ST_SETUP;
                                idx   <= 5'd1;
                            end
                            CMD_FRAME: begin
                                state   <= ST_FRAME;
                                idx     <= 5'd1;
                                shift_q <= '0;
                            end
                            CMD_POWER: begin
                                state <= ST_SKIP;
                                idx   <= 5'd1;
                            end
                            CMD_BULK: begin
                                state <= ST_SKIP;
                                idx   <= 5'd2;
                            end
                            default: ;
                        endcase
                    end
                    ST_SKIP: begin
                        if (idx == 5'd1) begin
                            state <= ST_IDLE;
                        end
                        idx <= idx - 1'b1;
                    end
                    ST_SETUP: begin
                        if ((idx == 5'd1 && rx_byte != CMD_FRAME) ||
                            idx == 5'd4) begin
                            state <= ST_IDLE;
                        end
                        idx <= idx + 1'b1;
                    end
                    ST_FRAME: begin
                        shift_q <= frame_next;
                        idx     <= idx + 1'b1;
                        if (frame_done) begin
                            state <= ST_IDLE;
                            lock  <= 1'b0;
                            if (all_ready) begin
                                frame_wr_en <= 1'b1;
                                frame_data  <= frame_next;
                                frame_count <= frame_count + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout) begin
                state <= ST_IDLE;
                lock  <= 1'b0;
            end else if (state == ST_ERR_HOLD) begin
                state <= ST_IDLE;
            end
        end
    end

    resp_fifo #(
        .DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_byte(push_byte),
        .pop      (tx_ready),
        .head     (tx_byte),
        .valid    (tx_valid),
        .count    (fifo_count)
    );

endmodule

// File: doc/serial_cmd_engine.md
# serial_cmd_engine

Parametrised host-command engine between the USB-UART byte layer and the per-console frame buffers. It parses host commands from a received byte stream and assembles frames of configurable byte width for up to NUM_CONSOLES consoles. It queues response bytes in an internal FIFO and issues flow-control 'A' requests when every console has room. UART_RX/UART_TX sit outside the block and connect through byte-level valid/ready ports. The block adds inter-byte timeout recovery, response-FIFO overflow reporting and a host-visible frame counter.

## Interface
- NUM_CONSOLES, 1: number of console buffers gating frame requests.
- FRAME_BYTES, 4: payload bytes following an 'A' command; range 1..16.
- RESP_DEPTH, 8: response FIFO depth; power of two, ≥4.
- TIMEOUT_CYCLES, 50000: idle cycles allowed mid-command before abort.
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid. Minimum spacing between strobes is 2 cycles.
- rx_byte  in  8  received byte.
- tx_valid  out  1  response FIFO is non-empty.
- tx_byte  out  8  head of the response FIFO (first-word fall-through).
- tx_ready  in  1  TX layer accepts tx_byte; the FIFO pops on tx_valid && tx_ready.
- request_frame  in  NUM_CONSOLES  per-console "buffer not full".
- frame_wr_en  out  1  one-cycle frame write strobe.
- frame_data  out  8*FRAME_BYTES  assembled frame; the first received byte is in the MSBs.
- controller_reset  out  1  one-cycle pulse on 'R'.
- frame_count  out  32  count of frames accepted since the last 'R' or rst.
- prebuffer_done  out  1  initial prebuffer phase is complete.
- resp_overflow  out  1  sticky flag; a push was dropped because the FIFO was full.

## Operation
- Reset values: all outputs 0, FIFO empty, parser in IDLE, request lock clear.
- Parser states: IDLE, SKIP (n bytes remaining), SETUP (byte index 1..4), FRAME (byte index), ERR_HOLD.
- Command decode in IDLE:
  - 'R' (0x52): pulse controller_reset, clear frame_count, clear prebuffer_done, clear the lock, respond 0x01 then 0x52.
  - 'S' (0x53): enter SETUP.
    - Byte 1 must be 0x41; otherwise respond 0xFE and return to IDLE.
    - Bytes 2–4 are accepted unchecked.
    - After byte 4, respond 0x01 then 0x53.
  - 'A' (0x41): enter FRAME and collect FRAME_BYTES bytes.
    - After the last byte, if &request_frame: pulse frame_wr_en and increment frame_count (wraps at 2^32).
    - Otherwise respond 0xB0 (overrun) and leave frame_count unchanged.
    - In either case, clear the request lock.
  - 0xAA: respond 0x55.
  - 'P' (0x50): skip 1 byte. 'Q' (0x51): skip 2 bytes. No response for either.
  - Any other byte: respond 0xFF.
- Responses are pushed one byte per cycle. A pending second byte takes priority over a new push.
- Request generation: push 0x41 when all of the following hold:
  - prebuffer_done
  - &request_frame
  - the lock is clear
  - no command response is being pushed that cycle

  Pushing the 0x41 sets the lock.
- prebuffer_done sets the first cycle that request_frame == 0. It clears only on 'R' or rst.
- Timeout: in SETUP/FRAME/SKIP, a counter counts cycles without rx_valid. On reaching TIMEOUT_CYCLES, push 0xFC, discard the partial command, clear the lock and return to IDLE. Any rx_valid reloads the counter.
- FIFO full on push: drop the byte and set resp_overflow. Only rst clears resp_overflow; 'R' does not.
- Simultaneous push and pop on a full FIFO: the push is accepted.

## Timing
- Response byte pushed at cycle N: tx_valid is high at N+1.
- Two-byte responses are pushed at N and N+1.
- frame_wr_en is high in the cycle after the rx_valid of the last payload byte.
  - frame_data is stable from that cycle until the next frame completes.
- controller_reset is high in the cycle after the 'R' strobe.
- frame_count updates in the same cycle as frame_wr_en.
- rst asserted mid-command: state clears immediately (asynchronously). The partial frame is never written.

## Structure
- Package serial_cmd_pkg holds:
  - command byte constants (CMD_RESET, CMD_SETUP, CMD_FRAME, CMD_PING, CMD_POWER, CMD_BULK);
  - response constants (RSP_ACK 0x01, RSP_PONG 0x55, RSP_OVERRUN 0xB0, RSP_BADRUN 0xFE, RSP_UNKNOWN 0xFF, RSP_TIMEOUT 0xFC);
  - the parser state enum.
- Sub-module resp_fifo: byte-wide, depth RESP_DEPTH, first-word fall-through, with count output. The parser, request logic and timeout counter live in the top level.

## Test plan
- rst, then 'R' → controller_reset pulse; tx stream 0x01, 0x52; frame_count=0.
- request_frame=0 then all-ones → prebuffer_done=1; exactly one 0x41 on tx until a frame is received.
- 'A' + 0x11,0x22,0x33,0x44 with request_frame all-ones → frame_wr_en once, frame_data=0x11223344, frame_count=1, a new 0x41 issued.
- Same frame with one request_frame bit low → no frame_wr_en; tx 0xB0; frame_count unchanged.
- 'S', 0x42 → tx 0xFE. 'S','A','M',0x80,0x00 → tx 0x01, 0x53. 0xAA → 0x55. 0x7E → 0xFF. 'Q',x,y → no response.
- 'A', 2 bytes, then silence for TIMEOUT_CYCLES → tx 0xFC, no write.
- tx_ready=0 with RESP_DEPTH+1 pings → resp_overflow=1; the FIFO drains RESP_DEPTH×0x55 after tx_ready rises.
